// File: rtl/riscv_cpu_pkg.sv
// Shared types for the RV32IM pipeline: operation encodings, control
// structs, the ID/EX and EX/MEM pipeline payloads, and bubble constants.
package riscv_cpu_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
  } alu_op_e;

  // Encoded in funct3 order: bit 2 marks the divide group, bit 1 selects
  // remainder and bit 0 marks the unsigned variants of DIV/REM.
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
    MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE, BR_JUMP} branch_mux_e;

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src_imm;
    logic    alu_src_pc;
    logic    md_en;
    md_op_e  md_op;
  } ex_ctl_t;

  typedef struct packed {
    logic        mem_we;
    logic        mem_re;
    branch_mux_e branch_mux;
  } mem_ctl_t;

  typedef struct packed {
    logic reg_we;
    logic mem_to_reg;
  } wb_ctl_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            dest_reg;
  } id2ex_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] branch_addr;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [4:0]            dest_reg;
  } ex2mem_t;

  localparam ex_ctl_t  EX_BUBBLE  = '{alu_op: ALU_ADD, alu_src_imm: 1'b0, alu_src_pc: 1'b0,
                                      md_en: 1'b0, md_op: MD_MUL};
  localparam mem_ctl_t MEM_BUBBLE = '{mem_we: 1'b0, mem_re: 1'b0, branch_mux: BR_NONE};
  localparam wb_ctl_t  WB_BUBBLE  = '{reg_we: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/ex_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Ports: clk_i/rst_i (sync, active-high); start_i launches an operation
// from IDLE with signed_i/rem_i selecting the variant; kill_i aborts.
// busy_o is high while iterating, done_o for the single result cycle, and
// result_o carries the sign-corrected quotient/remainder during done_o.
//
// state    | meaning
// DIV_IDLE | waiting for start_i
// DIV_RUN  | one shift/subtract step per cycle, counter counts down
// DIV_DONE | result_o valid for one cycle, then back to IDLE
module ex_divider
  import riscv_cpu_pkg::*;
#(
  parameter int DIV_CYCLES = DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic                  rem_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic                  kill_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] quo_q, rem_q, dvs_q, spec_q;
  logic                  neg_quo_q, neg_rem_q, rem_sel_q, special_q;
  logic                  a_neg, b_neg, div_zero, div_ovf;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic [DATA_WIDTH:0]   rem_shift, rem_diff;

  assign a_neg    = signed_i & dividend_i[DATA_WIDTH-1];
  assign b_neg    = signed_i & divisor_i[DATA_WIDTH-1];
  assign a_mag    = a_neg ? -dividend_i : dividend_i;
  assign b_mag    = b_neg ? -divisor_i : divisor_i;
  assign div_zero = (divisor_i == '0);
  assign div_ovf  = signed_i && (dividend_i == MIN_NEG) && (divisor_i == '1);

  // Partial remainder shifted left with the next dividend bit; a borrow out
  // of the 33-bit difference means the divisor did not fit (restore).
  assign rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};

  always_ff @(posedge clk_i) begin
    if (rst_i || kill_i) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      spec_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
      special_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            rem_sel_q <= rem_i;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            special_q <= div_zero | div_ovf;
            if (div_zero) spec_q <= rem_i ? dividend_i : '1;
            else          spec_q <= rem_i ? '0 : MIN_NEG;
            if (div_zero || div_ovf) begin
              state_q <= DIV_DONE;
            end else begin
              quo_q   <= a_mag;
              rem_q   <= '0;
              dvs_q   <= b_mag;
              cnt_q   <= CNT_W'(DIV_CYCLES);
              state_q <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          if (!rem_diff[DATA_WIDTH]) begin
            rem_q <= rem_diff[DATA_WIDTH-1:0];
            quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= rem_shift[DATA_WIDTH-1:0];
            quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= DIV_DONE;
        end
        DIV_DONE: state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == DIV_RUN);
  assign done_o = (state_q == DIV_DONE);

  always_comb begin
    result_o = quo_q;
    if (special_q)      result_o = spec_q;
    else if (rem_sel_q) result_o = neg_rem_q ? -rem_q : rem_q;
    else if (neg_quo_q) result_o = -quo_q;
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the RV32IM pipeline: ALU, single-cycle multiplier,
// iterative divider and branch-target adder feeding the EX/MEM register.
// Ports: clk_i/rst_i (sync, active-high); valid_i/flush_i qualify the
// instruction in EX; ex_ctl_i/mem_ctl_i/wb_ctl_i/ex_pipeline_i carry the
// ID/EX payload; mem_ctl_o/wb_ctl_o/mem_pipeline_o are the registered
// EX/MEM payload; stall_o (combinational) holds IF/ID during a divide.
module ex_stage
  import riscv_cpu_pkg::*;
#(
  parameter int DIV_CYCLES = DATA_WIDTH
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     valid_i,
  input  logic     flush_i,
  input  ex_ctl_t  ex_ctl_i,
  input  mem_ctl_t mem_ctl_i,
  input  wb_ctl_t  wb_ctl_i,
  input  id2ex_t   ex_pipeline_i,
  output mem_ctl_t mem_ctl_o,
  output wb_ctl_t  wb_ctl_o,
  output ex2mem_t  mem_pipeline_o,
  output logic     stall_o
);

  logic [DATA_WIDTH-1:0]          op_a, op_b, alu_result, md_result, ex_result, div_result;
  logic [4:0]                     shamt;
  logic                           mul_a_signed, mul_b_signed;
  logic signed [DATA_WIDTH:0]     mul_a, mul_b;
  logic signed [2*DATA_WIDTH-1:0] mul_prod;
  logic                           is_div, div_start, div_busy, div_done;

  assign op_a  = ex_ctl_i.alu_src_pc  ? ex_pipeline_i.pc  : ex_pipeline_i.rs1_data;
  assign op_b  = ex_ctl_i.alu_src_imm ? ex_pipeline_i.imm : ex_pipeline_i.rs2_data;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_result = '0;
    case (ex_ctl_i.alu_op)
      ALU_ADD:   alu_result = op_a + op_b;
      ALU_SUB:   alu_result = op_a - op_b;
      ALU_AND:   alu_result = op_a & op_b;
      ALU_OR:    alu_result = op_a | op_b;
      ALU_XOR:   alu_result = op_a ^ op_b;
      ALU_SLL:   alu_result = op_a << shamt;
      ALU_SRL:   alu_result = op_a >> shamt;
      ALU_SRA:   alu_result = $signed(op_a) >>> shamt;
      ALU_SLT:   alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_result = {{(DATA_WIDTH-1){1'b0}}, op_a < op_b};
      ALU_PASSB: alu_result = op_b;
      default:   alu_result = '0;
    endcase
  end

  // One 33x33 signed multiplier covers all four MUL variants: each operand
  // is sign- or zero-extended by one bit depending on the variant.
  assign mul_a_signed = (ex_ctl_i.md_op == MD_MULH) || (ex_ctl_i.md_op == MD_MULHSU);
  assign mul_b_signed = (ex_ctl_i.md_op == MD_MULH);
  assign mul_a        = {mul_a_signed & op_a[DATA_WIDTH-1], op_a};
  assign mul_b        = {mul_b_signed & op_b[DATA_WIDTH-1], op_b};
  assign mul_prod     = (2*DATA_WIDTH)'(mul_a) * (2*DATA_WIDTH)'(mul_b);
  assign md_result    = (ex_ctl_i.md_op == MD_MUL) ? mul_prod[DATA_WIDTH-1:0]
                                                   : mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];

  assign is_div    = ex_ctl_i.md_en && ex_ctl_i.md_op[2];
  // The divide instruction is still presented during DIV_DONE, so the
  // divider must be fully idle before a new start is accepted.
  assign div_start = valid_i && is_div && !flush_i && !rst_i && !div_busy && !div_done;
  assign stall_o   = !rst_i && !flush_i && (div_start || div_busy);

  ex_divider #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_divider (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (div_start),
    .signed_i   (!ex_ctl_i.md_op[0]),
    .rem_i      (ex_ctl_i.md_op[1]),
    .dividend_i (op_a),
    .divisor_i  (op_b),
    .kill_i     (flush_i),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .result_o   (div_result)
  );

  assign ex_result = div_done ? div_result : (ex_ctl_i.md_en ? md_result : alu_result);

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && (div_done || (valid_i && !stall_o))) begin
      mem_ctl_o                  <= mem_ctl_i;
      wb_ctl_o                   <= wb_ctl_i;
      mem_pipeline_o.pc          <= ex_pipeline_i.pc;
      mem_pipeline_o.branch_addr <= ex_pipeline_i.pc + ex_pipeline_i.imm;
      mem_pipeline_o.alu_result  <= ex_result;
      mem_pipeline_o.mem_wdata   <= ex_pipeline_i.rs2_data;
      mem_pipeline_o.dest_reg    <= ex_pipeline_i.dest_reg;
    end else begin
      mem_ctl_o      <= MEM_BUBBLE;
      wb_ctl_o       <= WB_BUBBLE;
      mem_pipeline_o <= '0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import riscv_cpu_pkg::*;

  logic     clk = 1'b0;
  logic     rst, valid, flush, stall;
  ex_ctl_t  ex_ctl;
  mem_ctl_t mem_ctl, mem_ctl_out;
  wb_ctl_t  wb_ctl, wb_ctl_out;
  id2ex_t   id_pipe;
  ex2mem_t  ex_mem_out;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .valid_i        (valid),
    .flush_i        (flush),
    .ex_ctl_i       (ex_ctl),
    .mem_ctl_i      (mem_ctl),
    .wb_ctl_i       (wb_ctl),
    .ex_pipeline_i  (id_pipe),
    .mem_ctl_o      (mem_ctl_out),
    .wb_ctl_o       (wb_ctl_out),
    .mem_pipeline_o (ex_mem_out),
    .stall_o        (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required below 1000000", $time);
    $fatal(1);
  end

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [31:0] ref_alu(alu_op_e op, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint d  = longint'(1) << b[4:0];
    longint r;
    case (op)
      ALU_ADD:   r = ua + ub;
      ALU_SUB:   r = ua - ub;
      ALU_AND:   r = ua & ub;
      ALU_OR:    r = ua | ub;
      ALU_XOR:   r = ua ^ ub;
      ALU_SLL:   r = ua * d;
      ALU_SRL:   r = ua / d;
      ALU_SRA:   r = (sa >= 0) ? sa / d : -((-sa + d - 1) / d);
      ALU_SLT:   r = (sa < sb) ? 1 : 0;
      ALU_SLTU:  r = (ua < ub) ? 1 : 0;
      ALU_PASSB: r = ub;
      default:   r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_mul(md_op_e op, logic [31:0] a, logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint          ua = longint'(a);
    longint unsigned pu = longint'(a) * longint'(b);
    longint          p;
    case (op)
      MD_MUL:    p = ua * longint'(b);
      MD_MULH:   p = sa * sb;
      MD_MULHSU: p = sa * longint'(b);
      default:   p = longint'(pu);
    endcase
    return (op == MD_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic bit ref_div_special(md_op_e op, logic [31:0] a, logic [31:0] b);
    bit sgn = (op == MD_DIV) || (op == MD_REM);
    return (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(md_op_e op, logic [31:0] a, logic [31:0] b);
    bit     sgn = (op == MD_DIV) || (op == MD_REM);
    bit     rem = (op == MD_REM) || (op == MD_REMU);
    longint x   = sgn ? longint'($signed(a)) : longint'(a);
    longint y   = sgn ? longint'($signed(b)) : longint'(b);
    longint r;
    if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
    r = rem ? (x % y) : (x / y);
    return r[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_instr(ex_ctl_t c, logic [31:0] pc, logic [31:0] rs1,
                           logic [31:0] rs2, logic [31:0] imm);
    ex_ctl           = c;
    id_pipe.pc       = pc;
    id_pipe.rs1_data = rs1;
    id_pipe.rs2_data = rs2;
    id_pipe.imm      = imm;
    id_pipe.dest_reg = 5'($urandom);
    mem_ctl          = mem_ctl_t'(4'($urandom));
    wb_ctl           = wb_ctl_t'(2'($urandom));
    valid            = 1'b1;
    flush            = 1'b0;
  endtask

  function automatic ex_ctl_t mk_alu(alu_op_e op, bit src_imm);
    ex_ctl_t c = EX_BUBBLE;
    c.alu_op = op;
    c.alu_src_imm = src_imm;
    return c;
  endfunction

  function automatic ex_ctl_t mk_md(md_op_e op);
    ex_ctl_t c = EX_BUBBLE;
    c.md_en = 1'b1;
    c.md_op = op;
    return c;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_instr(mk_alu(ALU_ADD, 1'b0), 32'h40, 32'h11, 32'h22, 32'h4);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ex_mem_out !== '0 || mem_ctl_out !== MEM_BUBBLE || wb_ctl_out !== WB_BUBBLE || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got pipe=%h mem=%h wb=%h stall=%b, required all 0", ex_mem_out, mem_ctl_out, wb_ctl_out, stall);
    end
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
  endtask

  task automatic test_alu_directed();
    logic [31:0] exp_res[2] = '{32'h8000_0000, 32'hF800_0000};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) set_instr(mk_alu(ALU_ADD, 1'b0), 32'h200, 32'h7FFF_FFFF, 32'h1, 32'h0);
      else        set_instr(mk_alu(ALU_SRA, 1'b1), 32'h204, 32'h8000_0000, 32'h0, 32'h4);
      #1;
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL alu_dir_stall[%0d]: got %b required 0", i, stall);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ex_mem_out.alu_result !== exp_res[i]) begin
        errors++;
        $display("FAIL alu_dir_result[%0d]: got %h required %h", i, ex_mem_out.alu_result, exp_res[i]);
      end
    end
  endtask

  task automatic test_branch();
    mem_ctl_t mc;
    wb_ctl_t  wc;
    @(negedge clk);
    set_instr(mk_alu(ALU_SUB, 1'b0), 32'h100, 32'h55, 32'h55, 32'hFFFF_FFF0);
    mem_ctl = '{mem_we: 1'b0, mem_re: 1'b0, branch_mux: BR_EQ};
    wb_ctl  = '{reg_we: 1'b0, mem_to_reg: 1'b1};
    mc = mem_ctl;
    wc = wb_ctl;
    @(posedge clk);
    #1;
    checks++;
    if (ex_mem_out.branch_addr !== 32'h0000_00F0 || ex_mem_out.alu_result !== 32'h0) begin
      errors++;
      $display("FAIL branch_addr: got addr=%h res=%h required addr=000000f0 res=0", ex_mem_out.branch_addr, ex_mem_out.alu_result);
    end
    checks++;
    if (mem_ctl_out !== mc || wb_ctl_out !== wc) begin
      errors++;
      $display("FAIL branch_ctl_pass: got mem=%h wb=%h required mem=%h wb=%h", mem_ctl_out, wb_ctl_out, mc, wc);
    end
  endtask

  task automatic test_alu_random();
    ex_ctl_t     c;
    logic [31:0] a, b, exp_res, exp_br;
    mem_ctl_t    mc;
    wb_ctl_t     wc;
    logic [4:0]  rd;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      c = mk_alu(alu_op_e'(4'($urandom_range(0, 10))), 1'($urandom));
      c.alu_src_pc = 1'($urandom);
      set_instr(c, $urandom, $urandom, $urandom, $urandom);
      a = c.alu_src_pc ? id_pipe.pc : id_pipe.rs1_data;
      b = c.alu_src_imm ? id_pipe.imm : id_pipe.rs2_data;
      exp_res = ref_alu(c.alu_op, a, b);
      exp_br  = 32'(longint'(id_pipe.pc) + longint'(id_pipe.imm));
      mc = mem_ctl;
      wc = wb_ctl;
      rd = id_pipe.dest_reg;
      #1;
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL alu_rand_stall[%0d]: got %b required 0", i, stall);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ex_mem_out.alu_result !== exp_res) begin
        errors++;
        $display("FAIL alu_rand_result[%0d] op=%0d: got %h required %h", i, c.alu_op, ex_mem_out.alu_result, exp_res);
      end
      checks++;
      if (ex_mem_out.branch_addr !== exp_br || ex_mem_out.mem_wdata !== id_pipe.rs2_data ||
          ex_mem_out.dest_reg !== rd || ex_mem_out.pc !== id_pipe.pc || mem_ctl_out !== mc || wb_ctl_out !== wc) begin
        errors++;
        $display("FAIL alu_rand_pass[%0d]: got br=%h wd=%h rd=%0d mem=%h wb=%h required br=%h wd=%h rd=%0d mem=%h wb=%h",
                 i, ex_mem_out.branch_addr, ex_mem_out.mem_wdata, ex_mem_out.dest_reg, mem_ctl_out, wb_ctl_out,
                 exp_br, id_pipe.rs2_data, rd, mc, wc);
      end
    end
  endtask

  task automatic test_mul();
    md_op_e      op;
    logic [31:0] exp_res;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      op = (i == 0) ? MD_MULHU : md_op_e'(3'($urandom_range(0, 3)));
      if (i == 0) set_instr(mk_md(op), 32'h300, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
      else        set_instr(mk_md(op), 32'h300, $urandom, $urandom, 32'h0);
      exp_res = (i == 0) ? 32'hFFFF_FFFE : ref_mul(op, id_pipe.rs1_data, id_pipe.rs2_data);
      #1;
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL mul_stall[%0d]: got %b required 0", i, stall);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ex_mem_out.alu_result !== exp_res) begin
        errors++;
        $display("FAIL mul_result[%0d] op=%0d: got %h required %h", i, op, ex_mem_out.alu_result, exp_res);
      end
    end
  endtask

  task automatic run_div(md_op_e op, logic [31:0] a, logic [31:0] b);
    logic [31:0] exp_res = ref_div(op, a, b);
    int          exp_stalls = ref_div_special(op, a, b) ? 1 : 33;
    int          n = 0;
    logic [4:0]  rd;
    wb_ctl_t     wc;
    @(negedge clk);
    set_instr(mk_md(op), 32'h400, a, b, 32'h0);
    rd = id_pipe.dest_reg;
    wc = wb_ctl;
    #1;
    while (stall === 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      checks++;
      if (ex_mem_out !== '0 || mem_ctl_out !== MEM_BUBBLE || wb_ctl_out !== WB_BUBBLE) begin
        errors++;
        $display("FAIL div_bubble op=%0d cycle=%0d: got pipe=%h required 0", op, n, ex_mem_out);
      end
      n++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (n != exp_stalls) begin
      errors++;
      $display("FAIL div_stall_cycles op=%0d a=%h b=%h: got %0d required %0d", op, a, b, n, exp_stalls);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ex_mem_out.alu_result !== exp_res || ex_mem_out.dest_reg !== rd || wb_ctl_out !== wc) begin
      errors++;
      $display("FAIL div_result op=%0d a=%h b=%h: got %h rd=%0d wb=%h required %h rd=%0d wb=%h",
               op, a, b, ex_mem_out.alu_result, ex_mem_out.dest_reg, wb_ctl_out, exp_res, rd, wc);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_div_directed();
    run_div(MD_DIV,  32'hFFFF_FFF9, 32'h2);
    run_div(MD_REM,  32'hFFFF_FFF9, 32'h2);
    run_div(MD_DIVU, 32'h5, 32'h0);
    run_div(MD_REMU, 32'h5, 32'h0);
    run_div(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    run_div(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run_div(MD_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_div_random();
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_div(md_op_e'(3'($urandom_range(4, 7))), $urandom, b);
    end
  endtask

  task automatic test_flush_and_invalid();
    @(negedge clk);
    set_instr(mk_md(MD_DIV), 32'h500, 32'd100, 32'd7, 32'h0);
    valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL invalid_div_stall: got %b required 0", stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ex_mem_out !== '0 || wb_ctl_out !== WB_BUBBLE) begin
      errors++;
      $display("FAIL invalid_bubble: got pipe=%h required 0", ex_mem_out);
    end
    @(negedge clk);
    valid = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b required 0", stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ex_mem_out !== '0 || mem_ctl_out !== MEM_BUBBLE || wb_ctl_out !== WB_BUBBLE) begin
      errors++;
      $display("FAIL flush_bubble: got pipe=%h required 0", ex_mem_out);
    end
    @(negedge clk);
    set_instr(mk_alu(ALU_ADD, 1'b0), 32'h504, 32'd3, 32'd4, 32'h0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_then_add_stall: got %b required 0", stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ex_mem_out.alu_result !== 32'd7) begin
      errors++;
      $display("FAIL flush_then_add: got %h required 00000007", ex_mem_out.alu_result);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_instr(mk_md(MD_DIVU), 32'h600, 32'd1000, 32'd3, 32'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ex_mem_out !== '0 || mem_ctl_out !== MEM_BUBBLE || wb_ctl_out !== WB_BUBBLE || stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_div: got pipe=%h stall=%b required 0", ex_mem_out, stall);
    end
    @(negedge clk);
    rst = 1'b0;
    set_instr(mk_alu(ALU_XOR, 1'b1), 32'h604, 32'hF0F0_F0F0, 32'h0, 32'hFFFF_0000);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_then_add_stall: got %b required 0", stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ex_mem_out.alu_result !== 32'h0F0F_F0F0) begin
      errors++;
      $display("FAIL rst_then_xor: got %h required 0f0ff0f0", ex_mem_out.alu_result);
    end
    @(negedge clk);
    set_instr(mk_alu(ALU_ADD, 1'b0), 32'h608, 32'd9, 32'd9, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ex_mem_out !== '0 || mem_ctl_out !== MEM_BUBBLE || wb_ctl_out !== WB_BUBBLE || stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid_add: got pipe=%h stall=%b required 0", ex_mem_out, stall);
    end
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    flush = 1'b0;
    ex_ctl = EX_BUBBLE;
    mem_ctl = MEM_BUBBLE;
    wb_ctl = WB_BUBBLE;
    id_pipe = '0;
    test_reset();
    test_alu_directed();
    test_branch();
    test_alu_random();
    test_mul();
    test_div_directed();
    test_div_random();
    test_flush_and_invalid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
